am2901_vgen: RTL and testbench

Synthesizable vector generator for the Am2901 ALU slice. It steps through 12-bit vector indices and drives a two-phase stimulus into an `am2901` instance: first a Q-register load, then an execute step. It captures the ALU's 10 result/flag bits and writes them, one word per index, through a request/acknowledge write port. It produces on hardware the response table that the Am2901 simulation bench reads as `vec_2901.vec`, using the same bit layout.

---
 rtl/am2901_vgen.sv | 122 ++++++++++++
 tb/tb_am2901_vgen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am2901_vgen.sv
// Am2901 response-table generator: per index, loads Q, executes one ALU op,
// captures Y and flags, and writes the 12-bit word through a req/ack port.
module am2901_vgen #(
  parameter int unsigned FIRST  = 0,
  parameter int unsigned LAST   = 4095,
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [8:0]  alu_i,
  output logic [3:0]  alu_d,
  output logic        alu_cin,
  input  logic [3:0]  alu_y,
  input  logic        alu_zf,
  input  logic        alu_f3,
  input  logic        alu_ovr,
  input  logic        alu_cout,
  input  logic        alu_p_n,
  input  logic        alu_g_n,
  output logic [11:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        wr_req,
  input  logic        wr_ack
);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, WRITE, DONE} state_t;

  typedef struct packed {
    logic [8:0] i;
    logic [3:0] d;
    logic       cin;
  } alu_drv_t;

  localparam logic [11:0] FIRST_N  = 12'(FIRST);
  localparam logic [11:0] LAST_N   = 12'(LAST);
  localparam logic [3:0]  CNT_INIT = 4'(SETTLE - 1);
  localparam alu_drv_t    DRV_IDLE = '{i: 9'o106, d: 4'h0, cin: 1'b0};

  state_t     state, state_d;
  logic [11:0] n, n_d;
  logic [3:0]  cnt, cnt_d;
  logic        cap;
  alu_drv_t    drv, drv_d;
  logic [11:0] word;

  assign word = {2'b00, alu_g_n, alu_p_n, alu_cout, alu_ovr, alu_f3, alu_zf, alu_y};

  always_comb begin
    state_d = state;
    n_d     = n;
    cnt_d   = cnt;
    cap     = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_d = LOAD;
        n_d     = FIRST_N;
      end
      LOAD: begin
        state_d = EXEC;
        cnt_d   = CNT_INIT;
      end
      EXEC: if (cnt == 4'd0) begin
        state_d = WRITE;
        cap     = 1'b1;
      end else begin
        cnt_d = cnt - 4'd1;
      end
      WRITE: if (wr_ack) begin
        if (n == LAST_N) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
          n_d     = n + 12'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU drive is decoded from the next state so it is valid for the whole
  // cycle the state is held, and stays a clean register output.
  always_comb begin
    drv_d = DRV_IDLE;
    case (state_d)
      LOAD:    drv_d = '{i: 9'b000_000_111, d: n_d[7:4], cin: 1'b0};
      EXEC:    drv_d = '{i: {3'b001, n_d[11:9], 3'b110}, d: n_d[3:0], cin: n_d[8]};
      default: drv_d = DRV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      n       <= 12'h000;
      cnt     <= 4'h0;
      drv     <= DRV_IDLE;
      wr_data <= 12'h000;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_req  <= 1'b0;
    end else begin
      state   <= state_d;
      n       <= n_d;
      cnt     <= cnt_d;
      drv     <= drv_d;
      if (cap) wr_data <= word;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      wr_req  <= (state_d == WRITE);
    end
  end

  assign alu_i   = drv.i;
  assign alu_d   = drv.d;
  assign alu_cin = drv.cin;
  assign wr_addr = n;

endmodule

// File: tb/tb_am2901_vgen.sv
// Bench for am2901_vgen: three generator instances share a clock, each driving
// its own behavioural Am2901 slice; a transaction model checks every cycle.
module tb_am2901_vgen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  start_v = '0;
  logic [2:0]  ack_v = '0;
  logic [2:0]  busy_v, done_v, wr_req_v, alu_cin_v;
  logic [8:0]  alu_i_v [3];
  logic [3:0]  alu_d_v [3];
  logic [3:0]  q [3];
  logic [9:0]  alu_o [3];
  logic [11:0] wr_addr_v [3];
  logic [11:0] wr_data_v [3];

  localparam logic [11:0] FIRSTS [3] = '{12'h1A5, 12'h00C, 12'h000};
  localparam logic [11:0] LASTS  [3] = '{12'h1A5, 12'h01F, 12'hFFF};

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_n [3];
  logic        due [3];
  int          writes [3];
  int          done_cnt [3];
  logic [11:0] last_data [3];

  always #5 clk = ~clk;

  // Am2901 ALU: returns {g_n, p_n, cout, ovr, f3, zf, f[3:0]}
  function automatic logic [9:0] alu_fn(input logic [2:0] fn, input logic [3:0] r_in,
                                        input logic [3:0] s_in, input logic c);
    logic [3:0] r, s, p, g, f;
    logic [4:0] sum, lo;
    logic pn, gn, co, ov, x1, x2;
    r = (fn == 3'd1 || fn == 3'd5 || fn == 3'd6) ? ~r_in : r_in;
    s = (fn == 3'd2) ? ~s_in : s_in;
    p = r | s;
    g = r & s;
    sum = '0; lo = '0; x1 = 1'b0; x2 = 1'b0;
    case (fn)
      3'd0, 3'd1, 3'd2: begin
        sum = {1'b0, r} + {1'b0, s} + {4'b0, c};
        lo  = {2'b0, r[2:0]} + {2'b0, s[2:0]} + {4'b0, c};
        f   = sum[3:0];
        co  = sum[4];
        ov  = lo[3] ^ sum[4];
        pn  = ~&p;
        gn  = ~(g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | (&p[3:1]) & g[0]);
      end
      3'd3: begin
        f = r | s; pn = 1'b0; gn = &p; co = ~(&p) | c; ov = co;
      end
      3'd4, 3'd5: begin
        f = r & s; pn = 1'b0; gn = ~(|g); co = (|g) | c; ov = co;
      end
      default: begin
        f  = ~(r ^ s);
        pn = |g;
        gn = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | (&p);
        co = ~(g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | (&p[3:1]) & (g[0] | c));
        x1 = ~p[2] | ~g[2] & ~p[1] | ~g[2] & ~g[1] & ~p[0] | ~g[2] & ~g[1] & ~g[0] & c;
        x2 = ~p[3] | ~g[3] & ~p[2] | ~g[3] & ~g[2] & ~p[1] | ~g[3] & ~g[2] & ~g[1] & ~p[0]
           | ~g[3] & ~g[2] & ~g[1] & ~g[0] & c;
        ov = x1 ^ x2;
      end
    endcase
    return {gn, pn, co, ov, f[3], (f == 4'h0), f};
  endfunction

  // Slice driven by the DUT pins; A/B RAM addresses are tied to 0 and RAM is empty.
  function automatic logic [9:0] alu_eval(input logic [8:0] i, input logic [3:0] d,
                                          input logic cin, input logic [3:0] qr);
    logic [3:0] r, s;
    case (i[2:0])
      3'd6:       begin r = d;    s = qr;   end
      3'd7, 3'd5: begin r = d;    s = 4'h0; end
      3'd0, 3'd2: begin r = 4'h0; s = qr;   end
      default:    begin r = 4'h0; s = 4'h0; end
    endcase
    return alu_fn(i[5:3], r, s, cin);
  endfunction

  // Expected table word for index n: Q = n[7:4], D = n[3:0], op n[11:9], cin n[8].
  function automatic logic [11:0] ref_word(input logic [11:0] n);
    return {2'b00, alu_fn(n[11:9], n[3:0], n[7:4], n[8])};
  endfunction

  assign alu_o[0] = alu_eval(alu_i_v[0], alu_d_v[0], alu_cin_v[0], q[0]);
  assign alu_o[1] = alu_eval(alu_i_v[1], alu_d_v[1], alu_cin_v[1], q[1]);
  assign alu_o[2] = alu_eval(alu_i_v[2], alu_d_v[2], alu_cin_v[2], q[2]);

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (alu_i_v[k][8:6] == 3'b000) q[k] <= alu_o[k][3:0];
  end

  am2901_vgen #(.FIRST(12'h1A5), .LAST(12'h1A5), .SETTLE(1)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .alu_i(alu_i_v[0]), .alu_d(alu_d_v[0]), .alu_cin(alu_cin_v[0]),
    .alu_y(alu_o[0][3:0]), .alu_zf(alu_o[0][4]), .alu_f3(alu_o[0][5]), .alu_ovr(alu_o[0][6]),
    .alu_cout(alu_o[0][7]), .alu_p_n(alu_o[0][8]), .alu_g_n(alu_o[0][9]),
    .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]), .wr_req(wr_req_v[0]), .wr_ack(ack_v[0]));

  am2901_vgen #(.FIRST(12'h00C), .LAST(12'h01F), .SETTLE(1)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .alu_i(alu_i_v[1]), .alu_d(alu_d_v[1]), .alu_cin(alu_cin_v[1]),
    .alu_y(alu_o[1][3:0]), .alu_zf(alu_o[1][4]), .alu_f3(alu_o[1][5]), .alu_ovr(alu_o[1][6]),
    .alu_cout(alu_o[1][7]), .alu_p_n(alu_o[1][8]), .alu_g_n(alu_o[1][9]),
    .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]), .wr_req(wr_req_v[1]), .wr_ack(ack_v[1]));

  am2901_vgen #(.FIRST(0), .LAST(4095), .SETTLE(2)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .alu_i(alu_i_v[2]), .alu_d(alu_d_v[2]), .alu_cin(alu_cin_v[2]),
    .alu_y(alu_o[2][3:0]), .alu_zf(alu_o[2][4]), .alu_f3(alu_o[2][5]), .alu_ovr(alu_o[2][6]),
    .alu_cout(alu_o[2][7]), .alu_p_n(alu_o[2][8]), .alu_g_n(alu_o[2][9]),
    .wr_addr(wr_addr_v[2]), .wr_data(wr_data_v[2]), .wr_req(wr_req_v[2]), .wr_ack(ack_v[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: writes come in ascending index order from FIRST, a
  // done pulse follows the cycle in which LAST is acknowledged.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic due_now;
      if (rst) begin
        exp_n[k] = FIRSTS[k];
        due[k]   = 1'b0;
        continue;
      end
      due_now = 1'b0;
      chk("done", done_v[k], due[k]);
      if (done_v[k]) done_cnt[k]++;
      if (!busy_v[k])
        chk("idle_drive", {wr_req_v[k], alu_i_v[k], alu_d_v[k], alu_cin_v[k]},
            {1'b0, 9'o106, 4'h0, 1'b0});
      if (wr_req_v[k]) begin
        chk("wr_addr", wr_addr_v[k], exp_n[k]);
        chk("wr_data", wr_data_v[k], ref_word(exp_n[k]));
        if (ack_v[k]) begin
          writes[k]++;
          last_data[k] = wr_data_v[k];
          if (exp_n[k] == LASTS[k]) begin
            due_now  = 1'b1;
            exp_n[k] = FIRSTS[k];
          end else begin
            exp_n[k] = exp_n[k] + 12'd1;
          end
        end
      end
      due[k] = due_now;
    end
  end

  task automatic pulse_start(input int k);
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
  endtask

  task automatic wait_load(input int k);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_i_v[k] == 9'o007) return;
    end
    chk("load_timeout", alu_i_v[k], 9'o007);
  endtask

  task automatic wait_req(input int k);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wr_req_v[k]) return;
    end
    chk("req_timeout", wr_req_v[k], 1);
  endtask

  task automatic wait_done(input int k, input int budget, output int cyc);
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done_v[k]) begin
        cyc = i;
        return;
      end
    end
    chk("done_timeout", done_v[k], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0, d0;
    logic [11:0] a0, dd0;
    for (int k = 0; k < 3; k++) begin
      writes[k] = 0; done_cnt[k] = 0; exp_n[k] = FIRSTS[k]; due[k] = 1'b0; last_data[k] = '0;
    end

    // Hand-derived table words pin the reference model.
    // 0x1A5: ADD, D=5 Q=A cin=1 -> F=0 carry out, P all ones, G none.
    chk("ref_1a5", ref_word(12'h1A5), 12'h290);
    chk("ref_000", ref_word(12'h000), 12'h310);
    chk("ref_2ff", ref_word(12'h2FF), 12'h22F);
    chk("ref_8c3", ref_word(12'h8C3), 12'h210);

    // asynchronous reset mid-cycle, before any clock edge
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++)
      chk("reset_values", {busy_v[k], done_v[k], wr_req_v[k], wr_addr_v[k], wr_data_v[k],
                           alu_i_v[k], alu_d_v[k], alu_cin_v[k]},
          {3'b000, 12'h000, 12'h000, 9'o106, 4'h0, 1'b0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single vector
    ack_v[0] = 1'b1;
    @(posedge clk); #1;
    pulse_start(0);
    wait_load(0);
    wait_done(0, 20, n);
    chk("a_done_latency", n, 3);
    repeat (3) @(negedge clk);
    chk("a_writes", writes[0], 1);
    chk("a_word", last_data[0], 12'h290);
    chk("a_done_count", done_cnt[0], 1);

    // backpressure on the first write of u_b
    w0 = writes[1];
    d0 = done_cnt[1];
    ack_v[1] = 1'b0;
    @(posedge clk); #1;
    pulse_start(1);
    wait_req(1);
    a0 = wr_addr_v[1];
    dd0 = wr_data_v[1];
    chk("bp_first_addr", a0, 12'h00C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold", {wr_req_v[1], wr_addr_v[1], wr_data_v[1]}, {1'b1, a0, dd0});
    end
    @(posedge clk); #1 ack_v[1] = 1'b1;
    @(posedge clk); #1 ack_v[1] = 1'b0;
    @(negedge clk);
    chk("bp_next", {wr_req_v[1], wr_addr_v[1], alu_i_v[1]}, {1'b0, 12'h00D, 9'o007});

    // random acknowledge, random start pulses while busy
    for (int i = 0; i < 2000 && done_cnt[1] == d0; i++) begin
      @(posedge clk); #1;
      ack_v[1]   = 1'($urandom_range(0, 1));
      start_v[1] = busy_v[1] ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start_v[1] = 1'b0;
    ack_v[1]   = 1'b0;
    repeat (4) @(negedge clk);
    chk("b_done_count", done_cnt[1], d0 + 1);
    chk("b_writes", writes[1] - w0, 20);

    // reset while WRITE of index 0x010 waits for acknowledge
    d0 = done_cnt[1];
    ack_v[1] = 1'b1;
    @(posedge clk); #1;
    pulse_start(1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      ack_v[1] = !(wr_req_v[1] && wr_addr_v[1] == 12'h010);
      if (!ack_v[1]) break;
    end
    chk("mid_in_write", {wr_req_v[1], wr_addr_v[1]}, {1'b1, 12'h010});
    #1 rst = 1'b1;
    #1;
    chk("mid_reset", {busy_v[1], done_v[1], wr_req_v[1], wr_addr_v[1], wr_data_v[1], alu_i_v[1]},
        {3'b000, 12'h000, 12'h000, 9'o106});
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_done_after_reset", done_cnt[1], d0);

    ack_v[1] = 1'b1;
    @(posedge clk); #1;
    pulse_start(1);
    wait_req(1);
    chk("restart_first", wr_addr_v[1], 12'h00C);
    wait_done(1, 200, n);
    repeat (2) @(negedge clk);
    chk("restart_done_count", done_cnt[1], d0 + 1);

    // full sweep, SETTLE=2, zero wait
    w0 = writes[2];
    ack_v[2] = 1'b1;
    @(posedge clk); #1;
    pulse_start(2);
    wait_load(2);
    wait_done(2, 17000, n);
    chk("c_done_latency", n, 4 * 4096);
    repeat (2) @(negedge clk);
    chk("c_writes", writes[2] - w0, 4096);
    chk("c_done_count", done_cnt[2], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
